// File: rtl/pcie_perst_pkg.sv
// Shared definitions for the root-complex PCIe reset generator.
// State encoding, state width and ms-counter width live here.
package pcie_perst_pkg;

    localparam int ST_W  = 3;
    localparam int CNT_W = 16;

    localparam logic [7:0] RST_CNT_MAX = 8'hFF;

    typedef enum logic [ST_W-1:0] {
        OFF      = 3'b000,
        PWR_WAIT = 3'b001,
        RUN      = 3'b010,
        ASSERT   = 3'b011
    } perst_state_e;

endpackage

// File: rtl/pcie_perst_sync.sv
// Two-flop synchronizer for one asynchronous input, plus an edge-detect
// flop. Provides the synchronized level and a one-clock rising pulse.
module pcie_perst_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic edge_q;

    // Synchronizer chain followed by the delayed copy used for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            edge_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~edge_q;

endmodule

// File: rtl/pcie_perst_gen.sv
// Root-complex PCIe reset (rc_pcie_rst, active-low) sequencer.
// Releases reset after PWR_DLY_MS ms of stable power-good and re-asserts it
// for at least ASSERT_MS ms on every host reset request.
// Optional macro PERST_RST_CNT_EN adds rst_cnt, a saturating count of exits
// from RUN.
module pcie_perst_gen
    import pcie_perst_pkg::*;
#(
    parameter int PWR_DLY_MS = 100,
    parameter int ASSERT_MS  = 20
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            int_1ms_en,
    input  logic            pwr_good,
    input  logic            host_rst_req,
    output logic            rc_pcie_rst,
    output logic            link_ready,
    output logic [ST_W-1:0] perst_state
`ifdef PERST_RST_CNT_EN
    ,
    output logic [7:0]      rst_cnt
`endif
);

    localparam logic [CNT_W-1:0] PWR_TGT    = CNT_W'(PWR_DLY_MS);
    localparam logic [CNT_W-1:0] ASSERT_TGT = CNT_W'(ASSERT_MS);

    logic             pg_s;
    logic             pg_rise_unused;
    logic             req_level_unused;
    logic             req_pe;
    perst_state_e     state;
    logic [CNT_W-1:0] ms_cnt;

    pcie_perst_sync u_pg_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (pwr_good),
        .sync_out (pg_s),
        .rise     (pg_rise_unused)
    );

    pcie_perst_sync u_req_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (host_rst_req),
        .sync_out (req_level_unused),
        .rise     (req_pe)
    );

    // Reset-sequencing FSM with ms counter; outputs registered from next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= OFF;
            ms_cnt      <= '0;
            rc_pcie_rst <= 1'b0;
            link_ready  <= 1'b0;
        end else begin
            // NOTE: this increment is only a default; any non-blocking
            // assignment to ms_cnt later in this block wins, which is how a
            // state entry discards a tick arriving in the same clock.
            if (int_1ms_en && (state == PWR_WAIT || state == ASSERT)) begin
                ms_cnt <= ms_cnt + 1'b1;
            end
            case (state)
                OFF: begin
                    if (pg_s) begin
                        state  <= PWR_WAIT;
                        ms_cnt <= '0;
                    end
                end
                PWR_WAIT: begin
                    if (!pg_s) begin
                        state  <= OFF;
                        ms_cnt <= '0;
                    end else if (ms_cnt == PWR_TGT) begin
                        state       <= RUN;
                        ms_cnt      <= '0;
                        rc_pcie_rst <= 1'b1;
                        link_ready  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!pg_s) begin
                        state       <= OFF;
                        ms_cnt      <= '0;
                        rc_pcie_rst <= 1'b0;
                        link_ready  <= 1'b0;
                    end else if (req_pe) begin
                        state       <= ASSERT;
                        ms_cnt      <= '0;
                        rc_pcie_rst <= 1'b0;
                        link_ready  <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (!pg_s) begin
                        state  <= OFF;
                        ms_cnt <= '0;
                    end else if (req_pe) begin
                        ms_cnt <= '0;
                    end else if (ms_cnt == ASSERT_TGT) begin
                        state       <= RUN;
                        ms_cnt      <= '0;
                        rc_pcie_rst <= 1'b1;
                        link_ready  <= 1'b1;
                    end
                end
                // NOTE: the enum covers only four of eight encodings; an
                // upset register must still fall back to a safe, held state.
                default: begin
                    state       <= OFF;
                    ms_cnt      <= '0;
                    rc_pcie_rst <= 1'b0;
                    link_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign perst_state = state;

`ifdef PERST_RST_CNT_EN
    // Saturating count of RUN exits (re-reset requests and power losses).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_cnt <= '0;
        end else if (state == RUN && (!pg_s || req_pe) && rst_cnt != RST_CNT_MAX) begin
            rst_cnt <= rst_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pcie_perst_gen.sv
// Self-checking bench for pcie_perst_gen. Two instances share stimulus:
// u_dut (PWR_DLY_MS=5, ASSERT_MS=3) and u_dut0 (PWR_DLY_MS=2, ASSERT_MS=0).
// A countdown-style reference model predicts every output each clock.
module tb_pcie_perst_gen;

    logic clock        = 1'b0;
    logic reset        = 1'b1;
    logic int_1ms_en   = 1'b0;
    logic pwr_good     = 1'b0;
    logic host_rst_req = 1'b0;

    logic       rc_a, link_a, rc_b, link_b;
    logic [2:0] st_a, st_b;
`ifdef PERST_RST_CNT_EN
    logic [7:0] cnt_a, cnt_b;
`endif

    int  total    = 0;
    int  bad      = 0;
    int  edge_n   = 0;
    int  period   = 10;
    int  tick_ctr = 0;
    bit  mon_en   = 1'b0;

    always #5 clock = ~clock;

    pcie_perst_gen #(.PWR_DLY_MS(5), .ASSERT_MS(3)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .int_1ms_en   (int_1ms_en),
        .pwr_good     (pwr_good),
        .host_rst_req (host_rst_req),
        .rc_pcie_rst  (rc_a),
        .link_ready   (link_a),
        .perst_state  (st_a)
`ifdef PERST_RST_CNT_EN
        ,
        .rst_cnt      (cnt_a)
`endif
    );

    pcie_perst_gen #(.PWR_DLY_MS(2), .ASSERT_MS(0)) u_dut0 (
        .clock        (clock),
        .reset        (reset),
        .int_1ms_en   (int_1ms_en),
        .pwr_good     (pwr_good),
        .host_rst_req (host_rst_req),
        .rc_pcie_rst  (rc_b),
        .link_ready   (link_b),
        .perst_state  (st_b)
`ifdef PERST_RST_CNT_EN
        ,
        .rst_cnt      (cnt_b)
`endif
    );

    // ---------------- reference model ----------------
    typedef enum {M_DOWN, M_POWER_DELAY, M_UP, M_HOLD} mphase_e;

    mphase_e ph[2]     = '{M_DOWN, M_DOWN};
    int      rem[2]    = '{0, 0};
    int      exits[2]  = '{0, 0};
    logic    pgp[2]    = '{1'b0, 1'b0};
    logic    rqp[3]    = '{1'b0, 1'b0, 1'b0};

    function automatic int pd_of(input int i);
        return (i == 0) ? 5 : 2;
    endfunction

    function automatic int am_of(input int i);
        return (i == 0) ? 3 : 0;
    endfunction

    function automatic logic [2:0] code_of(input mphase_e p);
        case (p)
            M_POWER_DELAY: return 3'b001;
            M_UP:          return 3'b010;
            M_HOLD:        return 3'b011;
            default:       return 3'b000;
        endcase
    endfunction

    always @(posedge clock or posedge reset) begin : model
        logic pg_now;
        logic pe_now;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                ph[i]    = M_DOWN;
                rem[i]   = 0;
                exits[i] = 0;
            end
            pgp = '{1'b0, 1'b0};
            rqp = '{1'b0, 1'b0, 1'b0};
        end else begin
            pg_now = pgp[1];
            pe_now = rqp[1] & ~rqp[2];
            for (int i = 0; i < 2; i++) begin
                case (ph[i])
                    M_DOWN: begin
                        if (pg_now) begin
                            ph[i]  = M_POWER_DELAY;
                            rem[i] = pd_of(i);
                        end
                    end
                    M_POWER_DELAY: begin
                        if (!pg_now)          ph[i] = M_DOWN;
                        else if (rem[i] == 0) ph[i] = M_UP;
                        else if (int_1ms_en)  rem[i]--;
                    end
                    M_UP: begin
                        if (!pg_now || pe_now) begin
                            if (exits[i] < 255) exits[i]++;
                            ph[i]  = pg_now ? M_HOLD : M_DOWN;
                            rem[i] = am_of(i);
                        end
                    end
                    default: begin
                        if (!pg_now)          ph[i] = M_DOWN;
                        else if (pe_now)      rem[i] = am_of(i);
                        else if (rem[i] == 0) ph[i] = M_UP;
                        else if (int_1ms_en)  rem[i]--;
                    end
                endcase
            end
            rqp[2] = rqp[1];
            rqp[1] = rqp[0];
            rqp[0] = host_rst_req;
            pgp[1] = pgp[0];
            pgp[0] = pwr_good;
        end
    end

    // Per-clock comparison of both instances against the model.
    always @(negedge clock) begin
        if (mon_en) begin
            total += 6;
            if (rc_a !== (ph[0] == M_UP)) begin
                bad++; $display("FAIL mon_rc_a edge=%0d got=%b want=%b", edge_n, rc_a, ph[0] == M_UP);
            end
            if (link_a !== (ph[0] == M_UP)) begin
                bad++; $display("FAIL mon_link_a edge=%0d got=%b want=%b", edge_n, link_a, ph[0] == M_UP);
            end
            if (st_a !== code_of(ph[0])) begin
                bad++; $display("FAIL mon_state_a edge=%0d got=%b want=%b", edge_n, st_a, code_of(ph[0]));
            end
            if (rc_b !== (ph[1] == M_UP)) begin
                bad++; $display("FAIL mon_rc_b edge=%0d got=%b want=%b", edge_n, rc_b, ph[1] == M_UP);
            end
            if (link_b !== (ph[1] == M_UP)) begin
                bad++; $display("FAIL mon_link_b edge=%0d got=%b want=%b", edge_n, link_b, ph[1] == M_UP);
            end
            if (st_b !== code_of(ph[1])) begin
                bad++; $display("FAIL mon_state_b edge=%0d got=%b want=%b", edge_n, st_b, code_of(ph[1]));
            end
`ifdef PERST_RST_CNT_EN
            total += 2;
            if (cnt_a !== 8'(exits[0])) begin
                bad++; $display("FAIL mon_cnt_a edge=%0d got=%0d want=%0d", edge_n, cnt_a, exits[0]);
            end
            if (cnt_b !== 8'(exits[1])) begin
                bad++; $display("FAIL mon_cnt_b edge=%0d got=%0d want=%0d", edge_n, cnt_b, exits[1]);
            end
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    // One clock: choose this edge's tick, let the edge pass, return at negedge.
    task automatic cyc();
        if (period == 0) begin
            int_1ms_en = ($urandom_range(0, 3) == 0);
        end else begin
            tick_ctr++;
            int_1ms_en = ((tick_ctr % period) == 0);
        end
        @(posedge clock);
        @(negedge clock);
        edge_n++;
    endtask

    // Runs until u_dut releases; expct = one edge after the nt-th tick
    // seen strictly after the entry edge.
    task automatic wait_release(input int entry, input int nt, output int seen, output int expct);
        int got;
        got   = 0;
        seen  = -1;
        expct = -1;
        for (int k = 0; k < 400 && seen < 0; k++) begin
            cyc();
            if (edge_n > entry && int_1ms_en && got < nt) begin
                got++;
                if (got == nt) expct = edge_n + 1;
            end
            if (rc_a === 1'b1 && seen < 0) seen = edge_n;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        total++;
        if ({rc_a, link_a, st_a, rc_b, link_b, st_b} !== 10'b0) begin
            bad++; $display("FAIL reset_outputs got=%b want=0", {rc_a, link_a, st_a, rc_b, link_b, st_b});
        end
`ifdef PERST_RST_CNT_EN
        total++;
        if ({cnt_a, cnt_b} !== 16'h0) begin
            bad++; $display("FAIL reset_cnt got=%h want=0", {cnt_a, cnt_b});
        end
`endif
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_power_up();
        int base, seen, expct;
        base     = edge_n;
        period   = 10;
        tick_ctr = 0;
        pwr_good = 1'b1;
        wait_release(base + 3, 5, seen, expct);
        total++;
        if (seen < 0 || seen !== expct) begin
            bad++; $display("FAIL power_up_release got_edge=%0d want_edge=%0d", seen, expct);
        end
        total++;
        if (link_a !== 1'b1 || st_a !== 3'b010) begin
            bad++; $display("FAIL power_up_run got=%b/%b want=1/010", link_a, st_a);
        end
    endtask

    task automatic test_pg_glitch();
        int base, seen, expct, got;
        base     = edge_n;
        pwr_good = 1'b0;
        cyc();
        cyc();
        total++;
        if (rc_a !== 1'b1) begin
            bad++; $display("FAIL pg_fall_early got=%b want=1", rc_a);
        end
        cyc();
        total++;
        if (rc_a !== 1'b0 || st_a !== 3'b000) begin
            bad++; $display("FAIL pg_fall_3clk got=%b/%b want=0/000", rc_a, st_a);
        end
        repeat (3) cyc();
        base     = edge_n;
        pwr_good = 1'b1;
        got      = 0;
        for (int k = 0; k < 100 && got < 3; k++) begin
            cyc();
            if (edge_n > base + 3 && int_1ms_en) got++;
        end
        base     = edge_n;
        pwr_good = 1'b0;
        cyc();
        cyc();
        pwr_good = 1'b1;
        cyc();
        total++;
        if (st_a !== 3'b000 || rc_a !== 1'b0) begin
            bad++; $display("FAIL glitch_off got=%b/%b want=000/0", st_a, rc_a);
        end
        wait_release(base + 5, 5, seen, expct);
        total++;
        if (seen < 0 || seen !== expct) begin
            bad++; $display("FAIL glitch_release got_edge=%0d want_edge=%0d", seen, expct);
        end
    endtask

    task automatic test_host_rereset();
        int base, seen, expct;
        base         = edge_n;
        host_rst_req = 1'b1;
        cyc();
        cyc();
        total++;
        if (rc_a !== 1'b1) begin
            bad++; $display("FAIL host_early got=%b want=1", rc_a);
        end
        host_rst_req = 1'b0;
        cyc();
        total++;
        if (rc_a !== 1'b0 || st_a !== 3'b011) begin
            bad++; $display("FAIL host_assert got=%b/%b want=0/011", rc_a, st_a);
        end
        wait_release(base + 3, 3, seen, expct);
        total++;
        if (seen < 0 || seen !== expct) begin
            bad++; $display("FAIL host_release got_edge=%0d want_edge=%0d", seen, expct);
        end
    endtask

    task automatic test_extended();
        int base, seen, expct, got;
        base         = edge_n;
        host_rst_req = 1'b1;
        cyc();
        cyc();
        host_rst_req = 1'b0;
        cyc();
        got = 0;
        for (int k = 0; k < 100 && got < 2; k++) begin
            cyc();
            if (edge_n > base + 3 && int_1ms_en) got++;
        end
        total++;
        if (st_a !== 3'b011 || got != 2) begin
            bad++; $display("FAIL ext_hold got=%b ticks=%0d want=011 ticks=2", st_a, got);
        end
        base         = edge_n;
        host_rst_req = 1'b1;
        cyc();
        cyc();
        host_rst_req = 1'b0;
        wait_release(base + 2, 3, seen, expct);
        total++;
        if (seen < 0 || seen !== expct) begin
            bad++; $display("FAIL ext_release got_edge=%0d want_edge=%0d", seen, expct);
        end
    endtask

    task automatic test_power_loss();
        int  base, seen, expct;
        bit  saw_assert;
`ifdef PERST_RST_CNT_EN
        logic [7:0] before;
        before = cnt_a;
`endif
        host_rst_req = 1'b1;
        cyc();
        cyc();
        host_rst_req = 1'b0;
        repeat (3) cyc();
        pwr_good = 1'b0;
        repeat (3) cyc();
        total++;
        if (st_a !== 3'b000 || rc_a !== 1'b0) begin
            bad++; $display("FAIL loss_in_assert got=%b/%b want=000/0", st_a, rc_a);
        end
`ifdef PERST_RST_CNT_EN
        total++;
        if (cnt_a !== before + 8'd1) begin
            bad++; $display("FAIL loss_cnt1 got=%0d want=%0d", cnt_a, before + 8'd1);
        end
`endif
        base     = edge_n;
        pwr_good = 1'b1;
        wait_release(base + 3, 5, seen, expct);
        total++;
        if (seen < 0 || seen !== expct) begin
            bad++; $display("FAIL loss_rerelease got_edge=%0d want_edge=%0d", seen, expct);
        end
`ifdef PERST_RST_CNT_EN
        before = cnt_a;
`endif
        saw_assert   = 1'b0;
        pwr_good     = 1'b0;
        host_rst_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (st_a === 3'b011) saw_assert = 1'b1;
        end
        host_rst_req = 1'b0;
        total++;
        if (st_a !== 3'b000 || rc_a !== 1'b0 || saw_assert) begin
            bad++; $display("FAIL loss_with_req got=%b/%b assert_seen=%b want=000/0/0", st_a, rc_a, saw_assert);
        end
`ifdef PERST_RST_CNT_EN
        total++;
        if (cnt_a !== before + 8'd1) begin
            bad++; $display("FAIL loss_cnt2 got=%0d want=%0d", cnt_a, before + 8'd1);
        end
`endif
    endtask

    task automatic test_async_reset();
        pwr_good = 1'b1;
        repeat (6) cyc();
        total++;
        if (st_a !== 3'b001) begin
            bad++; $display("FAIL async_pre got=%b want=001", st_a);
        end
        int_1ms_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++;
        if ({rc_a, link_a, st_a, rc_b, link_b, st_b} !== 10'b0) begin
            bad++; $display("FAIL async_reset got=%b want=0", {rc_a, link_a, st_a, rc_b, link_b, st_b});
        end
        @(negedge clock);
        edge_n++;
        reset = 1'b0;
    endtask

    task automatic test_assert_zero();
        int base;
        for (int k = 0; k < 200 && rc_b !== 1'b1; k++) cyc();
        total++;
        if (rc_b !== 1'b1) begin
            bad++; $display("FAIL zero_run_timeout got=%b want=1", rc_b);
        end
        base         = edge_n;
        host_rst_req = 1'b1;
        cyc();
        cyc();
        total++;
        if (rc_b !== 1'b1) begin
            bad++; $display("FAIL zero_early got=%b want=1", rc_b);
        end
        host_rst_req = 1'b0;
        cyc();
        total++;
        if (rc_b !== 1'b0 || st_b !== 3'b011) begin
            bad++; $display("FAIL zero_assert got=%b/%b want=0/011", rc_b, st_b);
        end
        cyc();
        total++;
        if (rc_b !== 1'b1 || st_b !== 3'b010) begin
            bad++; $display("FAIL zero_one_clock got=%b/%b want=1/010 base=%0d", rc_b, st_b, base);
        end
    endtask

    task automatic test_random();
        period = 0;
        for (int k = 0; k < 3000; k++) begin
            if (pwr_good) begin
                if ($urandom_range(0, 149) == 0) pwr_good = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) pwr_good = 1'b1;
            end
            if ($urandom_range(0, 14) == 0) host_rst_req = ~host_rst_req;
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_pg_glitch();
        test_host_rereset();
        test_extended();
        test_power_loss();
        test_async_reset();
        test_assert_zero();
        test_random();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcie_perst_gen.md
Name: pcie_perst_gen

Overview:
- Generates the root-complex PCIe reset (rc_pcie_rst, active-low: 0 = held in reset, rising edge = release).
- Sequences that reset from board power-good and from host reset requests, timed by the shared 1 ms tick.
- This is the driving end of the rc_pcie_rst line that the BMC reset logic consumes.
- Guarantees a stable power-good delay before first release, and a minimum assertion width on every re-reset.

Parameters:
- PWR_DLY_MS, 100, ms of stable synchronized power-good required before releasing reset; legal range 0..65535.
- ASSERT_MS, 20, minimum ms reset is held low for a host-requested re-reset; legal range 0..65535.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- int_1ms_en  in  1  one-clock-wide tick, once per ms, synchronous to clock.
- pwr_good  in  1  board power-good; asynchronous, synchronized internally.
- host_rst_req  in  1  asynchronous level; each rising edge requests a PCIe re-reset.
- rc_pcie_rst  out  1  registered; 0 = PCIe in reset, 1 = released.
- link_ready  out  1  registered; 1 only in state RUN.
- perst_state  out  3  current state encoding, for debug.

Behaviour:
- Reset: all flops 0.
  - rc_pcie_rst=0, link_ready=0, perst_state=OFF (3'b000).
  - Counter=0, synchronizers=0.
- Synchronization:
  - pwr_good: 2-flop synchronizer, giving pg_s.
  - host_rst_req: 2-flop synchronizer plus a third flop for edge detection; req_pe = s1 & ~s2 (one clock wide).
- Counter:
  - 16-bit, cleared on every state entry.
  - Increments by 1 in any clock where int_1ms_en=1 while in PWR_WAIT or ASSERT.
  - Never wraps, because the state is left when the counter equals the target.
- States (encoding in package):
  - OFF 000: rc_pcie_rst=0. When pg_s=1, next state PWR_WAIT.
  - PWR_WAIT 001: rc_pcie_rst=0.
    - pg_s=0 → OFF.
    - Otherwise, when counter==PWR_DLY_MS → RUN.
  - RUN 010: rc_pcie_rst=1, link_ready=1.
    - pg_s=0 → OFF (takes priority).
    - Otherwise req_pe=1 → ASSERT.
  - ASSERT 011: rc_pcie_rst=0.
    - pg_s=0 → OFF.
    - req_pe=1 → counter cleared, stay in ASSERT (the hold is extended).
    - Otherwise, when counter==ASSERT_MS → RUN.
  - Unused encodings → OFF.
- Outputs are registered from the next state.
  - rc_pcie_rst changes in the same edge that the state changes.
  - No combinational path exists from inputs to outputs.
- Latency:
  - pwr_good rising to rc_pcie_rst rising: 3 clocks (sync plus OFF→PWR_WAIT) plus PWR_DLY_MS ticks, plus 1 clock.
  - pwr_good falling to rc_pcie_rst=0: 3 clocks.
- Parameter value 0: the state is left on the first clock after entry, with no tick needed.
- Simultaneous events:
  - A tick in the same clock as a state entry is discarded, because the counter clears on entry.
  - req_pe in PWR_WAIT or OFF is ignored.
- Asynchronous reset mid-sequence forces OFF immediately, with rc_pcie_rst=0.

Optional Feature:
- Macro: PERST_RST_CNT_EN.
- When defined:
  - Adds output rst_cnt[7:0].
  - Increments on every RUN→ASSERT or RUN→OFF transition.
  - Saturates at 255 and is cleared only by reset.
- When undefined: the port and the counter are absent.

Decomposition:
- Package pcie_perst_pkg holds:
  - State localparams OFF/PWR_WAIT/RUN/ASSERT.
  - The state width (3).
  - The counter width (16).
- Sub-module pcie_perst_sync handles one asynchronous input:
  - 2-flop synchronizer plus edge-detect flop, with asynchronous active-high reset to 0.
  - Outputs: sync level, rising pulse.
  - Instantiated twice.

Test Plan:
1. Power-up: PWR_DLY_MS=5, tick every 10 clocks, pwr_good=1 at t0 → rc_pcie_rst=0 through 5 ticks, then 1 one clock after the 5th tick counted; link_ready=1.
2. Power-good glitch: pwr_good high for 3 ticks, low for 2 clocks, high again → returns to OFF; counter restarts; release comes only after a fresh 5 ticks.
3. Host re-reset: in RUN, ASSERT_MS=3, pulse host_rst_req → rc_pcie_rst=0 three clocks after the edge, and high again after 3 ticks.
4. Extended request: a second host_rst_req edge after 2 ticks in ASSERT → the hold restarts; 3 further ticks are required.
5. Power loss in ASSERT, and pwr_good=0 together with a request in RUN → OFF, rc_pcie_rst stays or goes 0, no transition to ASSERT; with PERST_RST_CNT_EN, rst_cnt increments by exactly 1.
6. Asynchronous reset asserted mid-PWR_WAIT, and ASSERT_MS=0 → all outputs 0 at once; with ASSERT_MS=0, ASSERT lasts exactly one clock.
